// File: rtl/multiword_add_pkg.sv
// Shared definitions for the multi-word add sequencer: slice width and FSM state type.
package multiword_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sixteen_bit_adder.sv
// Combinational 16-bit adder slice with carry in and carry out.
module sixteen_bit_adder
  import multiword_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  assign sum   = total[SLICE_W-1:0];
  assign cout  = total[SLICE_W];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Feeds a WORDS*16-bit add through one 16-bit adder, LSB slice first, with a registered carry.
// Optional subtract mode (sub port, ~b and forced carry-in) is enabled by defining SUB_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// RUN   | one slice per cycle through the adder, idx selects the slice
// DONE  | result held on sum/cout with out_valid until out_ready
module multiword_add_sequencer
  import multiword_add_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int SLICE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*SLICE-1:0] a,
  input  logic [WORDS*SLICE-1:0] b,
  input  logic                   cin,
`ifdef SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*SLICE-1:0] sum,
  output logic                   cout,
  output logic                   busy
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_t state_q, state_d;
  logic   capture, step;

  logic [WORDS-1:0][SLICE_W-1:0] a_q, b_q, sum_q;
  logic [WORDS-1:0][SLICE_W-1:0] b_eff;
  logic                          carry_q, cin_eff;
  logic [IDX_W-1:0]              idx_q;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

`ifdef SUB_EN
  // Two's-complement subtract: invert b and force the initial carry; cin is don't-care.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (idx_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sixteen_bit_adder u_adder (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // idx holds at LAST on the final slice so it never wraps inside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (capture) begin
      a_q     <= a;
      b_q     <= b_eff;
      carry_q <= cin_eff;
      idx_q   <= '0;
    end else if (step) begin
      sum_q[idx_q] <= slice_sum;
      carry_q      <= slice_cout;
      if (idx_q != LAST) idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Randomized self-checking bench for multiword_add_sequencer (WORDS=4), reference is plain wide arithmetic.
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int err_cnt = 0;
  int chk_cnt = 0;

  multiword_add_sequencer #(.WORDS(WORDS), .SLICE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {cout,sum} of the whole operation as one (W+1)-bit number.
  function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rcin, input logic rsub);
    logic [W:0] ea, eb, ec;
    ea = {1'b0, ra};
`ifdef SUB_EN
    if (rsub) begin
      eb = {1'b0, ~rb};
      ec = (W+1)'(1);
      return ea + eb + ec;
    end
`else
    if (rsub) begin end
`endif
    eb = {1'b0, rb};
    ec = (W+1)'(rcin);
    return ea + eb + ec;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                         input logic tsub, input int stall, input bit poke);
    logic [W:0] exp;
    int         n;
    bit         seen;
    exp = ref_result(ta, tb, tcin, tsub);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tb; cin = tcin;
`ifdef SUB_EN
    sub = tsub;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = 1'($urandom);
`ifdef SUB_EN
    sub = 1'($urandom);
`endif
    chk("busy_run", busy, 1);
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      if (poke && n == 1) begin
        chk("in_ready_run", in_ready, 0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
      end
      @(posedge clk);
      n++;
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (out_valid) seen = 1;
    end
    chk("latency", n, WORDS);
    chk("sum", sum, exp[W-1:0]);
    chk("cout", cout, exp[W]);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, exp[W-1:0]);
      chk("hold_cout", cout, exp[W]);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_busy", busy, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, 0);
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, 0);
    run_txn(64'h8000_7FFF_0001_FFFE, 64'h7FFF_8000_FFFF_0002, 1'b0, 1'b0, 5, 1);
    run_txn(64'h1234_1234_1234_1234, 64'h1111_1111_1111_1111, 1'b1, 1'b0, 0, 0);
    run_txn(64'h0, 64'h0, 1'b0, 1'b0, 0, 0);
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1, 0);

    // Reset two slices into RUN with large operands so the partial sum is non-zero.
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 64'hFFFF_FFFF_FFFF_FFFF;
    cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_run_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(64'h3, 64'h4, 1'b0, 1'b0, 0, 0);

`ifdef SUB_EN
    run_txn(64'h5, 64'h7, 1'b0, 1'b1, 0, 0);
    run_txn(64'h7, 64'h5, 1'b0, 1'b1, 0, 0);
    run_txn(64'h7, 64'h5, 1'b1, 1'b1, 2, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (t % 8 == 3) rb = ~ra;
      run_txn(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
